// File: rtl/branch_pkg.sv
// Shared decode constants and BHT state encoding for the branch resolution unit.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    localparam bht_state_e BHT_RST = WNT;

    function automatic logic bht_predict(input bht_state_e s);
        return (s == WT) || (s == ST);
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// Array of 2-bit saturating predictors with a lookup read port, a resolve read port
// and a single saturating-update write port at the resolve index.
module branch_history_table
    import branch_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] lookup_idx,
    input  logic [IDX_W-1:0] resolve_idx,
    input  logic             update,
    input  logic             update_taken,
    output logic             lookup_pred,
    output logic             resolve_pred
);

    bht_state_e bht_q [ENTRIES];
    bht_state_e resolve_state;
    bht_state_e next_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= BHT_RST;
            end
        end else if (update) begin
            bht_q[resolve_idx] <= next_state;
        end
    end

    always_comb begin
        resolve_state = bht_q[resolve_idx];
        next_state    = resolve_state;
        unique case (resolve_state)
            SNT: next_state = update_taken ? WNT : SNT;
            WNT: next_state = update_taken ? WT  : SNT;
            WT:  next_state = update_taken ? ST  : WNT;
            ST:  next_state = update_taken ? ST  : WT;
        endcase
    end

    // Reads see the registered array, so a same-cycle update is not forwarded.
    always_comb begin
        lookup_pred  = bht_predict(bht_q[lookup_idx]);
        resolve_pred = bht_predict(resolve_state);
    end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: funct3 decode, PC-select, illegal detection,
// BHT prediction/update and saturating branch/mispredict statistics.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        is_branch_i,
    input  logic        is_jal_i,
    input  logic        is_jalr_i,
    input  logic [2:0]  funct3_i,
    input  logic        br_equal_i,
    input  logic        br_less_i,
    input  logic [31:0] lookup_pc_i,
    output logic        br_unsigned_o,
    output logic        taken_o,
    output logic        pc_sel_o,
    output logic        illegal_o,
    output logic        pred_taken_o,
    output logic        mispredict_o,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispredict_cnt_o
);

    logic        cond;
    logic        reserved;
    logic        multi_hot;
    logic        resolve;
    logic        resolve_pred;
    logic [31:0] branch_cnt_q;
    logic [31:0] mispredict_cnt_q;
    logic        unused_pc_bits;

    assign unused_pc_bits = ^{pc_i[31:IDX_W+2], pc_i[1:0],
                              lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0]};

    always_comb begin
        br_unsigned_o = (funct3_i == F3_BLTU) || (funct3_i == F3_BGEU);
        cond          = 1'b0;
        reserved      = 1'b0;
        case (funct3_i)
            F3_BEQ:           cond = br_equal_i;
            F3_BNE:           cond = !br_equal_i;
            F3_BLT, F3_BLTU:  cond = br_less_i;
            F3_BGE, F3_BGEU:  cond = !br_less_i;
            default:          reserved = 1'b1;
        endcase
        multi_hot    = (is_branch_i & is_jal_i) | (is_branch_i & is_jalr_i) | (is_jal_i & is_jalr_i);
        illegal_o    = valid_i & ((is_branch_i & reserved) | multi_hot);
        taken_o      = valid_i & is_branch_i & cond;
        pc_sel_o     = valid_i & (is_jal_i | is_jalr_i | taken_o);
        resolve      = valid_i & is_branch_i & !illegal_o;
        mispredict_o = resolve & (resolve_pred != taken_o);
    end

    branch_history_table #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk          (clk),
        .rst          (rst),
        .lookup_idx   (lookup_pc_i[IDX_W+1:2]),
        .resolve_idx  (pc_i[IDX_W+1:2]),
        .update       (resolve),
        .update_taken (taken_o),
        .lookup_pred  (pred_taken_o),
        .resolve_pred (resolve_pred)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (resolve && (branch_cnt_q != '1)) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mispredict_o && (mispredict_cnt_q != '1)) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: decode vector table plus BHT, counter and reset sequences.
module tb_branch_resolver;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        is_branch_i = 1'b0;
    logic        is_jal_i = 1'b0;
    logic        is_jalr_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic        br_equal_i = 1'b0;
    logic        br_less_i = 1'b0;
    logic [31:0] lookup_pc_i = '0;
    logic        br_unsigned_o;
    logic        taken_o;
    logic        pc_sel_o;
    logic        illegal_o;
    logic        pred_taken_o;
    logic        mispredict_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispredict_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    branch_resolver #(.BHT_ENTRIES(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_i          (valid_i),
        .pc_i             (pc_i),
        .is_branch_i      (is_branch_i),
        .is_jal_i         (is_jal_i),
        .is_jalr_i        (is_jalr_i),
        .funct3_i         (funct3_i),
        .br_equal_i       (br_equal_i),
        .br_less_i        (br_less_i),
        .lookup_pc_i      (lookup_pc_i),
        .br_unsigned_o    (br_unsigned_o),
        .taken_o          (taken_o),
        .pc_sel_o         (pc_sel_o),
        .illegal_o        (illegal_o),
        .pred_taken_o     (pred_taken_o),
        .mispredict_o     (mispredict_o),
        .branch_cnt_o     (branch_cnt_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid, br, jal, jalr;
        logic [2:0] f3;
        logic       eq, lt;
        logic       e_taken, e_sel, e_ill, e_uns;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic valid, input logic br, input logic jal, input logic jalr,
                                input logic [2:0] f3, input logic eq, input logic lt,
                                input logic e_taken, input logic e_sel, input logic e_ill, input logic e_uns);
        vec_t v;
        v.valid = valid; v.br = br; v.jal = jal; v.jalr = jalr;
        v.f3 = f3; v.eq = eq; v.lt = lt;
        v.e_taken = e_taken; v.e_sel = e_sel; v.e_ill = e_ill; v.e_uns = e_uns;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        valid_i = 1'b0; is_branch_i = 1'b0; is_jal_i = 1'b0; is_jalr_i = 1'b0;
        funct3_i = 3'b000; br_equal_i = 1'b0; br_less_i = 1'b0;
    endtask

    task automatic drive_br(input logic [31:0] pc, input logic [2:0] f3, input logic eq, input logic lt);
        valid_i = 1'b1; is_branch_i = 1'b1; is_jal_i = 1'b0; is_jalr_i = 1'b0;
        pc_i = pc; funct3_i = f3; br_equal_i = eq; br_less_i = lt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // valid br jal jalr f3 eq lt | taken sel ill uns; eq/lt pairs 00, 01, 10
        add(1,1,0,0,3'b000,0,0, 0,0,0,0); add(1,1,0,0,3'b000,0,1, 0,0,0,0); add(1,1,0,0,3'b000,1,0, 1,1,0,0);
        add(1,1,0,0,3'b001,0,0, 1,1,0,0); add(1,1,0,0,3'b001,0,1, 1,1,0,0); add(1,1,0,0,3'b001,1,0, 0,0,0,0);
        add(1,1,0,0,3'b010,0,0, 0,0,1,0); add(1,1,0,0,3'b010,0,1, 0,0,1,0); add(1,1,0,0,3'b010,1,0, 0,0,1,0);
        add(1,1,0,0,3'b011,0,0, 0,0,1,0); add(1,1,0,0,3'b011,0,1, 0,0,1,0); add(1,1,0,0,3'b011,1,0, 0,0,1,0);
        add(1,1,0,0,3'b100,0,0, 0,0,0,0); add(1,1,0,0,3'b100,0,1, 1,1,0,0); add(1,1,0,0,3'b100,1,0, 0,0,0,0);
        add(1,1,0,0,3'b101,0,0, 1,1,0,0); add(1,1,0,0,3'b101,0,1, 0,0,0,0); add(1,1,0,0,3'b101,1,0, 1,1,0,0);
        add(1,1,0,0,3'b110,0,0, 0,0,0,1); add(1,1,0,0,3'b110,0,1, 1,1,0,1); add(1,1,0,0,3'b110,1,0, 0,0,0,1);
        add(1,1,0,0,3'b111,0,0, 1,1,0,1); add(1,1,0,0,3'b111,0,1, 0,0,0,1); add(1,1,0,0,3'b111,1,0, 1,1,0,1);
        add(0,1,0,0,3'b000,1,0, 0,0,0,0); add(0,1,0,0,3'b110,0,1, 0,0,0,1);
        add(1,0,1,0,3'b000,0,0, 0,1,0,0); add(1,0,0,1,3'b000,0,0, 0,1,0,0);
        add(1,1,1,0,3'b000,0,0, 0,1,1,0); add(1,0,1,1,3'b101,0,0, 0,1,1,0);
        add(1,0,0,0,3'b010,0,0, 0,0,0,0);

        // Decode table
        do_reset();
        pc_i = 32'h300;
        lookup_pc_i = 32'h300;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            valid_i = vecs[i].valid; is_branch_i = vecs[i].br; is_jal_i = vecs[i].jal; is_jalr_i = vecs[i].jalr;
            funct3_i = vecs[i].f3; br_equal_i = vecs[i].eq; br_less_i = vecs[i].lt;
            #1;
            check($sformatf("vec%0d taken", i), {31'd0, taken_o}, {31'd0, vecs[i].e_taken});
            check($sformatf("vec%0d pc_sel", i), {31'd0, pc_sel_o}, {31'd0, vecs[i].e_sel});
            check($sformatf("vec%0d illegal", i), {31'd0, illegal_o}, {31'd0, vecs[i].e_ill});
            check($sformatf("vec%0d unsigned", i), {31'd0, br_unsigned_o}, {31'd0, vecs[i].e_uns});
        end

        // First resolve after reset
        do_reset();
        lookup_pc_i = 32'h100;
        #1;
        check("rst branch_cnt", branch_cnt_o, 32'd0);
        check("rst mispredict_cnt", mispredict_cnt_o, 32'd0);
        check("rst pred", {31'd0, pred_taken_o}, 32'd0);
        @(negedge clk);
        drive_br(32'h100, F3_BEQ, 1'b1, 1'b0);
        #1;
        check("first taken", {31'd0, taken_o}, 32'd1);
        check("first pc_sel", {31'd0, pc_sel_o}, 32'd1);
        check("first mispredict", {31'd0, mispredict_o}, 32'd1);
        @(negedge clk);
        idle();
        #1;
        check("first branch_cnt", branch_cnt_o, 32'd1);
        check("first mispredict_cnt", mispredict_cnt_o, 32'd1);
        check("first pred", {31'd0, pred_taken_o}, 32'd1);

        // Saturating walk at 0x200
        do_reset();
        lookup_pc_i = 32'h200;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_br(32'h200, F3_BEQ, 1'b1, 1'b0);
            #1;
            check($sformatf("walk%0d mispredict", i), {31'd0, mispredict_o}, (i == 0) ? 32'd1 : 32'd0);
            check($sformatf("walk%0d pred old", i), {31'd0, pred_taken_o}, (i == 0) ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        drive_br(32'h200, F3_BEQ, 1'b0, 1'b0);
        #1;
        check("walk nt taken", {31'd0, taken_o}, 32'd0);
        check("walk nt mispredict", {31'd0, mispredict_o}, 32'd1);
        @(negedge clk);
        idle();
        #1;
        check("walk pred WT", {31'd0, pred_taken_o}, 32'd1);
        check("walk mispredict_cnt", mispredict_cnt_o, 32'd2);
        check("walk branch_cnt", branch_cnt_o, 32'd5);
        @(negedge clk);
        drive_br(32'h200, F3_BEQ, 1'b0, 1'b0);
        #1;
        check("walk nt2 mispredict", {31'd0, mispredict_o}, 32'd1);
        @(negedge clk);
        idle();
        #1;
        check("walk pred WNT", {31'd0, pred_taken_o}, 32'd0);
        check("walk mispredict_cnt2", mispredict_cnt_o, 32'd3);

        // Aliasing 0x004 / 0x104 and read-during-write
        do_reset();
        @(negedge clk);
        lookup_pc_i = 32'h104;
        drive_br(32'h004, F3_BNE, 1'b0, 1'b0);
        #1;
        check("alias same-cycle pred", {31'd0, pred_taken_o}, 32'd0);
        check("alias mispredict", {31'd0, mispredict_o}, 32'd1);
        @(negedge clk);
        idle();
        #1;
        check("alias next pred", {31'd0, pred_taken_o}, 32'd1);
        lookup_pc_i = 32'h008;
        #1;
        check("alias neighbour pred", {31'd0, pred_taken_o}, 32'd0);

        // Jumps and multi-hot
        do_reset();
        @(negedge clk);
        pc_i = 32'h010; lookup_pc_i = 32'h010;
        valid_i = 1'b1; is_jal_i = 1'b1; funct3_i = F3_BEQ; br_equal_i = 1'b0;
        #1;
        check("jal pc_sel", {31'd0, pc_sel_o}, 32'd1);
        check("jal taken", {31'd0, taken_o}, 32'd0);
        check("jal mispredict", {31'd0, mispredict_o}, 32'd0);
        @(negedge clk);
        is_branch_i = 1'b1; br_equal_i = 1'b1;
        #1;
        check("multi illegal", {31'd0, illegal_o}, 32'd1);
        check("multi pc_sel", {31'd0, pc_sel_o}, 32'd1);
        check("multi mispredict", {31'd0, mispredict_o}, 32'd0);
        @(negedge clk);
        valid_i = 1'b0; is_jal_i = 1'b0;
        #1;
        check("invalid pc_sel", {31'd0, pc_sel_o}, 32'd0);
        check("invalid mispredict", {31'd0, mispredict_o}, 32'd0);
        @(negedge clk);
        idle();
        #1;
        check("jump branch_cnt", branch_cnt_o, 32'd0);
        check("jump mispredict_cnt", mispredict_cnt_o, 32'd0);
        check("jump bht untouched", {31'd0, pred_taken_o}, 32'd0);

        // Counter saturation
        do_reset();
        @(negedge clk);
        force dut.branch_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.branch_cnt_q;
        lookup_pc_i = 32'h000;
        drive_br(32'h000, F3_BEQ, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        check("sat first", branch_cnt_o, 32'hFFFF_FFFF);
        @(negedge clk);
        idle();
        #1;
        check("sat hold", branch_cnt_o, 32'hFFFF_FFFF);
        check("sat mispredict_cnt", mispredict_cnt_o, 32'd1);

        // Reset wins over a concurrent resolve
        @(negedge clk);
        rst = 1'b1;
        drive_br(32'h000, F3_BEQ, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        check("rstwin branch_cnt", branch_cnt_o, 32'd0);
        check("rstwin mispredict_cnt", mispredict_cnt_o, 32'd0);
        for (int i = 0; i < 64; i++) begin
            lookup_pc_i = 32'(i * 4);
            #1;
            check($sformatf("rstwin pred%0d", i), {31'd0, pred_taken_o}, 32'd0);
        end
        @(negedge clk);
        lookup_pc_i = 32'h000;
        drive_br(32'h000, F3_BEQ, 1'b1, 1'b0);
        #1;
        check("rstwin mispredict", {31'd0, mispredict_o}, 32'd1);
        @(negedge clk);
        idle();
        #1;
        check("rstwin WNT->WT", {31'd0, pred_taken_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Branch resolution and prediction unit for the execute stage of the RV32I core. It decodes the B-type `funct3` and drives the unsigned-compare select to the branch comparator. It consumes the comparator's equal/less flags and produces the PC-select decision. It also maintains a 2-bit saturating branch history table (BHT) plus branch/mispredict statistics counters, ahead of the move to a pipelined fetch.

## Interface
Parameters:
- `BHT_ENTRIES`, 64, number of BHT entries; must be a power of two, minimum 2.
- `IDX_W`, `$clog2(BHT_ENTRIES)`, BHT index width; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  an instruction is executing this cycle.
- `pc_i`  in  32  PC of the executing instruction.
- `is_branch_i`  in  1  instruction is a conditional branch (B-type).
- `is_jal_i`  in  1  instruction is JAL.
- `is_jalr_i`  in  1  instruction is JALR.
- `funct3_i`  in  3  instruction `funct3` field.
- `br_equal_i`  in  1  comparator rs1 == rs2.
- `br_less_i`  in  1  comparator rs1 < rs2, signedness per `br_unsigned_o`.
- `lookup_pc_i`  in  32  fetch-side PC for prediction lookup.
- `br_unsigned_o`  out  1  comparator unsigned select.
- `taken_o`  out  1  conditional branch condition true.
- `pc_sel_o`  out  1  1 = next PC is the computed target; 0 = PC+4.
- `illegal_o`  out  1  branch with reserved `funct3`, or more than one of `is_*` set.
- `pred_taken_o`  out  1  BHT prediction for `lookup_pc_i`.
- `mispredict_o`  out  1  resolved branch disagrees with the BHT prediction for `pc_i`.
- `branch_cnt_o`  out  32  resolved conditional branches.
- `mispredict_cnt_o`  out  32  mispredicted conditional branches.

## Operation
- `br_unsigned_o` = 1 iff `funct3_i` is 110 or 111. It is independent of `valid_i`.
- Condition by `funct3_i`:
  - 000 BEQ: `eq`
  - 001 BNE: `!eq`
  - 100 BLT and 110 BLTU: `less`
  - 101 BGE and 111 BGEU: `!less`
  - 010 and 011: reserved; `taken_o` = 0.
- `taken_o` is gated by `valid_i & is_branch_i`.
- `pc_sel_o` = `valid_i & (is_jal_i | is_jalr_i | taken_o)`.
- `illegal_o` = `valid_i` & (a branch with reserved `funct3`, or more than one `is_*` asserted).
  - Multiple `is_*` asserted: `pc_sel_o` = 1 if any jump bit is set; no BHT or counter update.
- A resolve event is `valid_i & is_branch_i & !illegal_o`.
- BHT index is `pc[IDX_W+1:2]`. Each entry is a 4-state FSM: SNT(00), WNT(01), WT(10), ST(11).
  - Prediction is taken iff the state is WT or ST.
  - On resolve, taken: SNT→WNT→WT→ST, ST stays ST.
  - On resolve, not taken: ST→WT→WNT→SNT, SNT stays SNT.
- `mispredict_o` = resolve event & (prediction at index of `pc_i` ≠ `taken_o`).
- `branch_cnt_o` increments on each resolve event.
- `mispredict_cnt_o` increments on each `mispredict_o`.
- Both counters saturate at 0xFFFF_FFFF; no wrap.
- Jumps never touch the BHT or the counters.

## Timing
- All outputs except the two counters are combinational, same cycle.
- BHT and counter writes take effect at the next rising edge.
- Read-during-write:
  - Lookup at the index being updated this cycle returns the pre-update state.
  - The new state is visible the following cycle.
  - Same rule applies to the `pc_i` read feeding `mispredict_o`.
- Reset, synchronous, while `rst` is high at the edge:
  - Every BHT entry goes to WNT.
  - Both counters go to 0.
- After reset, `pred_taken_o` = 0 for every PC.
- `rst` asserted in the same cycle as a resolve event: reset wins; the update is discarded.
- `valid_i` = 0: `pc_sel_o`, `taken_o`, `illegal_o` and `mispredict_o` are 0, and no state changes.

## Structure
- Package `branch_pkg` holds:
  - `funct3` localparams `F3_BEQ`…`F3_BGEU`.
  - `typedef enum logic [1:0] bht_state_e {SNT, WNT, WT, ST}`.
  - Reset state constant `BHT_RST = WNT`.
- Sub-module `branch_history_table` holds:
  - The counter array with synchronous reset.
  - Two combinational read ports: lookup and resolve.
  - One write port carrying the saturating update.
- The top level holds the `funct3` decode, the `pc_sel` and `illegal` logic, and the statistics counters.

## Test plan
- Reset, then `funct3`=000, eq=1, `is_branch`=1, pc=0x100 → `taken`=1, `pc_sel`=1, `mispredict`=1; next cycle `branch_cnt`=1, `mispredict_cnt`=1, lookup 0x100 → `pred_taken`=1 (WT).
- Sweep all 8 `funct3` values × (eq, less) ∈ {00, 01, 10} → `taken` matches the table above; 010/011 give `illegal`=1 and `pc_sel`=0; `br_unsigned`=1 only for 110/111.
- Resolve taken at pc 0x200 four times → states WNT→WT→ST→ST; then not-taken → WT and `mispredict`=1; `mispredict_cnt` = 2 in total.
- pc 0x004 and 0x104 with `BHT_ENTRIES`=64 alias to index 1 → an update via 0x004 changes the 0x104 prediction; a same-cycle lookup at 0x104 shows the old value.
- JAL with `funct3`=000 and eq=0 → `pc_sel`=1, `taken`=0, counters unchanged; `is_jal` and `is_branch` both set → `illegal`=1, `pc_sel`=1, no BHT update.
- Force `branch_cnt` to 0xFFFF_FFFE, resolve twice → counter holds 0xFFFF_FFFF. Assert `rst` together with a resolve → all BHT entries WNT and counters 0 next cycle.
